// File: rtl/qdec_pkg.sv
// Shared phase encodings, direction constants and quadrature sequence helper
// for the quadrature decoder and its bench.
package qdec_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Up sequence is 00 -> 01 -> 11 -> 10 -> 00; down is its reverse.
    function automatic phase_e next_up(input phase_e p);
        case (p)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            PH_10:   return PH_00;
            default: return PH_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Phase inputs, clear and decoded outputs of the quadrature decoder.
interface quad_decoder_if #(
    parameter int WIDTH = 16
);
    logic             a;
    logic             b;
    logic             clr;
    logic [WIDTH-1:0] o_count;
    logic             o_dir;
    logic             o_step;
    logic             o_err;

    modport master (output a, b, clr, input o_count, o_dir, o_step, o_err);
    modport slave  (input a, b, clr, output o_count, o_dir, o_step, o_err);
endinterface

// File: rtl/qdec_sync.sv
// Input synchronizer for the A/B pair; optional glitch filter when
// QDEC_GLITCH_FILTER_EN is defined.
module qdec_sync
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILTER_EN
    , parameter int FILTER_CYCLES = 4
`endif
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_a,
    input  logic   i_b,
    output phase_e o_phase,
    output logic   o_valid
);
    localparam int FW = $clog2(SYNC_STAGES + 1);
    localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);

    logic [1:0]    r_sync [SYNC_STAGES];
    logic [FW-1:0] r_fill;
    logic          w_fill_done;

    assign w_fill_done = (r_fill == FILL_DONE);

    // Multi-stage synchronizer for both phase bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 2'b00;
        end else begin
            r_sync[0] <= {i_a, i_b};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Valid is withheld until the chain holds real samples, so priming never
    // latches the reset zeros and then sees a false double transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= {FW{1'b0}};
        end else if (!w_fill_done) begin
            r_fill <= r_fill + FILL_ONE;
        end
    end

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_stable;
    logic          r_stable_vld;

    // Accept a candidate only after FILTER_CYCLES identical samples in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand       <= 2'b00;
            r_cnt        <= {CW{1'b0}};
            r_stable     <= 2'b00;
            r_stable_vld <= 1'b0;
        end else if (w_fill_done) begin
            if (r_sync[SYNC_STAGES-1] != r_cand) begin
                r_cand <= r_sync[SYNC_STAGES-1];
                r_cnt  <= CNT_ONE;
            end else if (r_cnt == CNT_LAST) begin
                r_stable     <= r_cand;
                r_stable_vld <= 1'b1;
                r_cnt        <= CNT_FULL;
            end else if (r_cnt < CNT_LAST) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_phase = phase_e'(r_stable);
    assign o_valid = r_stable_vld;
`else
    assign o_phase = phase_e'(r_sync[SYNC_STAGES-1]);
    assign o_valid = w_fill_done;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: phase FSM, wrapping position counter, direction,
// step pulse and sticky error. Glitch filter enabled by QDEC_GLITCH_FILTER_EN.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILTER_EN
    , parameter int FILTER_CYCLES = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    quad_decoder_if.slave io_bus
);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    phase_e           w_phase;
    logic             w_valid;
    phase_e           r_state,   w_state_nxt;
    logic             r_primed,  w_primed_nxt;
    logic [WIDTH-1:0] r_count,   w_count_nxt;
    logic             r_dir,     w_dir_nxt;
    logic             r_step,    w_step_nxt;
    logic             r_err,     w_err_nxt;

    qdec_sync #(
        .SYNC_STAGES   (SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
        , .FILTER_CYCLES (FILTER_CYCLES)
`endif
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_a     (io_bus.a),
        .i_b     (io_bus.b),
        .o_phase (w_phase),
        .o_valid (w_valid)
    );

    // Phase state, priming flag and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= PH_00;
            r_primed <= 1'b0;
            r_count  <= CNT_ZERO;
            r_dir    <= DIR_DOWN;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_primed <= w_primed_nxt;
            r_count  <= w_count_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_step_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next phase and output values; clr overrides count, step and error
    always_comb begin
        w_state_nxt  = r_state;
        w_primed_nxt = r_primed;
        w_count_nxt  = r_count;
        w_dir_nxt    = r_dir;
        w_step_nxt   = 1'b0;
        w_err_nxt    = r_err;

        if (!r_primed) begin
            if (w_valid) begin
                w_state_nxt  = w_phase;
                w_primed_nxt = 1'b1;
            end else begin
                w_state_nxt  = r_state;
            end
        end else if (w_phase == r_state) begin
            w_step_nxt = 1'b0;
        end else if (next_up(r_state) == w_phase) begin
            w_state_nxt = w_phase;
            w_count_nxt = r_count + CNT_ONE;
            w_dir_nxt   = DIR_UP;
            w_step_nxt  = 1'b1;
        end else if (next_up(w_phase) == r_state) begin
            w_state_nxt = w_phase;
            w_count_nxt = r_count - CNT_ONE;
            w_dir_nxt   = DIR_DOWN;
            w_step_nxt  = 1'b1;
        end else begin
            w_state_nxt = w_phase;
            w_err_nxt   = 1'b1;
        end

        if (io_bus.clr) begin
            w_count_nxt = CNT_ZERO;
            w_step_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
        end else begin
            w_count_nxt = w_count_nxt;
        end
    end

    assign io_bus.o_count = r_count;
    assign io_bus.o_dir   = r_dir;
    assign io_bus.o_step  = r_step;
    assign io_bus.o_err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (default and glitch-filter builds).
module tb_quad_decoder;
    import qdec_pkg::*;

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses = 0;
    int   p0;
    phase_e ph;

    quad_decoder_if #(.WIDTH(16)) intf ();

    quad_decoder #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (intf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (intf.o_step) pulses <= pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_phase(input logic [1:0] p);
        @(negedge clk);
        {intf.a, intf.b} = p;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        intf.clr = 1'b1;
        @(negedge clk);
        intf.clr = 1'b0;
    endtask

    initial begin
        intf.a = 1'b1; intf.b = 1'b1; intf.clr = 1'b0;
        #1;
        check_eq("rst_count", 32'(intf.o_count), 32'h0);
        check_eq("rst_flags", {29'h0, intf.o_dir, intf.o_step, intf.o_err}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("prime_count", 32'(intf.o_count), 32'h0);
        check_eq("prime_err", 32'(intf.o_err), 32'h0);
        check_eq("prime_pulses", 32'(pulses), 32'h0);

        // 8 full up cycles starting from primed phase 11
        ph = PH_11;
        p0 = pulses;
        for (int i = 0; i < 32; i++) begin
            ph = next_up(ph);
            put_phase(ph);
        end
        check_eq("up32_count", 32'(intf.o_count), 32'd32);
        check_eq("up32_dir", 32'(intf.o_dir), 32'h1);
        check_eq("up32_pulses", 32'(pulses - p0), 32'd32);

        pulse_clr();
        check_eq("clr_count", 32'(intf.o_count), 32'h0);

        put_phase(2'b01);
        check_eq("wrap_dn_count", 32'(intf.o_count), 32'hFFFF);
        check_eq("wrap_dn_dir", 32'(intf.o_dir), 32'h0);
        put_phase(2'b11);
        check_eq("wrap_up_count", 32'(intf.o_count), 32'h0);
        check_eq("wrap_up_dir", 32'(intf.o_dir), 32'h1);

        // Illegal double transition 11 -> 00
        p0 = pulses;
        put_phase(2'b00);
        check_eq("ill_err", 32'(intf.o_err), 32'h1);
        check_eq("ill_count", 32'(intf.o_count), 32'h0);
        check_eq("ill_dir", 32'(intf.o_dir), 32'h1);
        check_eq("ill_nostep", 32'(pulses - p0), 32'h0);
        repeat (6) @(negedge clk);
        check_eq("ill_sticky", 32'(intf.o_err), 32'h1);
        put_phase(2'b01);
        check_eq("ill_resume_count", 32'(intf.o_count), 32'h1);
        check_eq("ill_resume_err", 32'(intf.o_err), 32'h1);
        pulse_clr();
        check_eq("ill_clr_err", 32'(intf.o_err), 32'h0);
        check_eq("ill_clr_count", 32'(intf.o_count), 32'h0);

        // Reach count 5, then clr collides with the next step
        put_phase(2'b11); put_phase(2'b10); put_phase(2'b00);
        put_phase(2'b01); put_phase(2'b11);
        check_eq("five_count", 32'(intf.o_count), 32'd5);
        p0 = pulses;
        @(negedge clk);
        {intf.a, intf.b} = 2'b10;
        repeat (LAT - 1) @(negedge clk);
        intf.clr = 1'b1;
        @(negedge clk);
        intf.clr = 1'b0;
        check_eq("coll_count", 32'(intf.o_count), 32'h0);
        check_eq("coll_step", 32'(pulses - p0), 32'h0);
        repeat (HOLD) @(negedge clk);
        put_phase(2'b00);
        check_eq("coll_next_count", 32'(intf.o_count), 32'h1);
        check_eq("coll_next_err", 32'(intf.o_err), 32'h0);

`ifdef QDEC_GLITCH_FILTER_EN
        // 2-cycle glitch on a must be ignored
        p0 = pulses;
        @(negedge clk);
        intf.a = 1'b1;
        repeat (2) @(negedge clk);
        intf.a = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("glitch_count", 32'(intf.o_count), 32'h1);
        check_eq("glitch_pulses", 32'(pulses - p0), 32'h0);
        check_eq("glitch_err", 32'(intf.o_err), 32'h0);
`endif

        // Step latency measured from the input edge
        @(negedge clk);
        {intf.a, intf.b} = 2'b01;
        repeat (LAT - 1) @(negedge clk);
        check_eq("lat_early", 32'(intf.o_step), 32'h0);
        @(negedge clk);
        check_eq("lat_step", 32'(intf.o_step), 32'h1);
        @(negedge clk);
        check_eq("lat_count", 32'(intf.o_count), 32'd2);
        check_eq("lat_pulse_width", 32'(intf.o_step), 32'h0);

        // Reset mid-operation with phase 01 held; priming must load 01
        rst_n = 1'b0;
        #1;
        check_eq("midrst_count", 32'(intf.o_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (12) @(negedge clk);
        check_eq("midrst_prime_count", 32'(intf.o_count), 32'h0);
        check_eq("midrst_prime_pulses", 32'(pulses - p0), 32'h0);
        put_phase(2'b11);
        check_eq("midrst_step_count", 32'(intf.o_count), 32'h1);
        check_eq("midrst_step_err", 32'(intf.o_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
